pc_count_to_thermo: RTL

- Inverse of the sorting-network parallel counter: converts a stream of binary counts (0..N) back into N-bit thermometer (sorted) vectors.
- Sits on the verification and reconstruction side of the parallel-counter datapath.
- Input and output are valid/ready streams.
- A 2-entry skid buffer gives full throughput with registered in_ready.
- Keeps a sticky range-error flag and a transfer counter.

---
 rtl/pc_thermo_pkg.sv | 27 ++
 rtl/pc_thermo_decode.sv | 25 ++
 rtl/pc_count_to_thermo.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pc_thermo_pkg.sv
// Shared definitions for the parallel-counter / thermometer family.
//   buf_state_e  : occupancy of the two-entry output skid buffer
//   thermo_of()  : reference count-to-thermometer conversion (up to 64 bits)
//   PC_N_DEFAULT : default number of counted bits in the family
//   PC_W_DEFAULT : matching binary count width
package pc_thermo_pkg;

   localparam int PC_N_DEFAULT = 15;
   localparam int PC_W_DEFAULT = $clog2(PC_N_DEFAULT + 1);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } buf_state_e;

   // Bit i is set when count > i; counts above n saturate to n ones.
   function automatic logic [63:0] thermo_of(input int unsigned count, input int unsigned n);
      logic [63:0] t;
      t = '0;
      for (int unsigned i = 0; i < 64; i++) begin
         t[i] = (i < n) && (count > i);
      end
      return t;
   endfunction

endpackage

// File: rtl/pc_thermo_decode.sv
// Combinational binary-count to thermometer decoder with saturation flag.
// Ports:
//   count  : binary count, 0..2^W-1
//   thermo : N-bit thermometer, bit i = (count > i), ones fill from bit 0
//   sat    : count exceeded N; thermo is then all ones
module pc_thermo_decode #(
   parameter int N = 15,
   parameter int W = $clog2(N + 1)
) (
   input  logic [W-1:0] count,
   output logic [N-1:0] thermo,
   output logic         sat
);

   // Counts above N naturally produce all ones, so saturation needs no extra mux.
   always_comb begin
      thermo = '0;
      for (int i = 0; i < N; i++) begin
         thermo[i] = (int'(count) > i);
      end
   end

   assign sat = (int'(count) > N);

endmodule

// File: rtl/pc_count_to_thermo.sv
// Stream converter: binary counts (0..N) in, N-bit thermometer words out.
// Words are decoded on entry and held in a two-entry skid buffer (main M
// drives the outputs, skid S absorbs one word of backpressure) so in_ready
// can be registered while sustaining one word per cycle.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : count stream handshake (in_ready registered)
//   in_count            : binary count, W bits
//   out_valid/out_ready : thermometer stream handshake
//   out_thermo          : thermometer word, bit i = (count > i)
//   range_err           : sticky, an accepted count exceeded N
//   err_clr             : synchronous clear of range_err (new error wins)
//   xfer_cnt            : accepted-word counter, wraps
//   ser_bit/ser_valid/ser_last : only with PC_THERMO_SER_EN defined; each
//                         output beat is replayed bit 0 first over N cycles
//                         and out_valid is held low meanwhile.
//
// Buffer states:
//   state | meaning
//   EMPTY | M and S invalid, out_valid low
//   ONE   | M valid, S invalid
//   FULL  | M and S valid, in_ready low
module pc_count_to_thermo
   import pc_thermo_pkg::*;
#(
   parameter int N     = PC_N_DEFAULT,
   parameter int W     = $clog2(N + 1),
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_count,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_thermo,
   output logic             range_err,
   input  logic             err_clr,
   output logic [CNT_W-1:0] xfer_cnt
`ifdef PC_THERMO_SER_EN
   ,
   output logic             ser_bit,
   output logic             ser_valid,
   output logic             ser_last
`endif
);

   buf_state_e   state;
   logic [N-1:0] m_data;
   logic [N-1:0] s_data;
   logic [N-1:0] dec_thermo;
   logic         dec_sat;
   logic         out_valid_q;
   logic         ser_busy;
   logic         accept;
   logic         pop;

   pc_thermo_decode #(
      .N (N),
      .W (W)
   ) u_decode (
      .count  (in_count),
      .thermo (dec_thermo),
      .sat    (dec_sat)
   );

   assign accept     = in_valid & in_ready;
   assign out_valid  = out_valid_q & ~ser_busy;
   assign pop        = out_valid & out_ready;
   assign out_thermo = m_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= EMPTY;
         m_data      <= '0;
         s_data      <= '0;
         out_valid_q <= 1'b0;
         in_ready    <= 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  m_data      <= dec_thermo;
                  out_valid_q <= 1'b1;
                  state       <= ONE;
               end
            end
            ONE: begin
               if (accept && !pop) begin
                  s_data   <= dec_thermo;
                  in_ready <= 1'b0;
                  state    <= FULL;
               end else if (pop && !accept) begin
                  out_valid_q <= 1'b0;
                  state       <= EMPTY;
               end else if (accept && pop) begin
                  m_data <= dec_thermo;
               end
            end
            FULL: begin
               // in_ready is low here, so only a pop can happen.
               if (pop) begin
                  m_data   <= s_data;
                  in_ready <= 1'b1;
                  state    <= ONE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready    <= 1'b1;
               state       <= EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         range_err <= 1'b0;
         xfer_cnt  <= '0;
      end else begin
         if (accept && dec_sat) begin
            range_err <= 1'b1;
         end else if (err_clr) begin
            range_err <= 1'b0;
         end
         if (accept) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
         end
      end
   end

`ifdef PC_THERMO_SER_EN
   localparam int SER_W = $clog2(N);

   logic [N-1:0]     ser_shift;
   logic [SER_W-1:0] ser_left;

   // ser_left counts the bits still to show after the current one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ser_valid <= 1'b0;
         ser_bit   <= 1'b0;
         ser_last  <= 1'b0;
         ser_shift <= '0;
         ser_left  <= '0;
      end else if (pop) begin
         ser_valid <= 1'b1;
         ser_bit   <= m_data[0];
         ser_shift <= m_data >> 1;
         ser_left  <= SER_W'(N - 1);
         ser_last  <= 1'b0;
      end else if (ser_valid) begin
         if (ser_left == '0) begin
            ser_valid <= 1'b0;
            ser_bit   <= 1'b0;
            ser_last  <= 1'b0;
         end else begin
            ser_bit   <= ser_shift[0];
            ser_shift <= ser_shift >> 1;
            ser_left  <= ser_left - SER_W'(1);
            ser_last  <= (ser_left == SER_W'(1));
         end
      end
   end

   assign ser_busy = ser_valid;
`else
   assign ser_busy = 1'b0;
`endif

endmodule
